// File: rtl/key_conditioner.sv
`default_nettype none
// key_conditioner: synchronises, debounces and edge-detects the active-low Run pushbutton.
// Optional macro KEYCOND_TOGGLE_EN builds a register that flips on every accepted press.
module key_conditioner #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic Clock,
  input  logic Resetn,
  input  logic KeyRaw,
  output logic Level,
  output logic Press,
  output logic Release,
  output logic Toggle
);

  localparam logic [1:0] IDLE         = 2'd0;
  localparam logic [1:0] PRESS_WAIT   = 2'd1;
  localparam logic [1:0] HELD         = 2'd2;
  localparam logic [1:0] RELEASE_WAIT = 2'd3;

  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             pressed_s;

  always_comb begin
    s1_d      = KeyRaw;
    s2_d      = s1_q;
    pressed_s = ~s2_q;

    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;

    // The counter is cleared on every state change and only advances while waiting.
    case (state_q)
      IDLE: begin
        if (pressed_s) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!pressed_s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_TERM) begin
          state_d = HELD;
          level_d = 1'b1;
          press_d = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HELD: begin
        if (!pressed_s) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (pressed_s) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_TERM) begin
          state_d   = IDLE;
          level_d   = 1'b0;
          release_d = 1'b1;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Synchroniser resets to "released" so a key held through reset needs a full debounce.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      s1_q      <= 1'b1;
      s2_q      <= 1'b1;
      state_q   <= IDLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign Level   = level_q;
  assign Press   = press_q;
  assign Release = release_q;

`ifdef KEYCOND_TOGGLE_EN
  logic toggle_q, toggle_d;

  always_comb begin
    toggle_d = toggle_q;
    if (press_d) toggle_d = ~toggle_q;
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) toggle_q <= 1'b0;
    else         toggle_q <= toggle_d;
  end

  assign Toggle = toggle_q;
`else
  assign Toggle = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_key_conditioner.sv
`default_nettype none
// tb_key_conditioner: directed stimulus with a pulse scoreboard, DEBOUNCE_CYCLES = 4.
module tb_key_conditioner;

  logic clk;
  logic rstn;
  logic key;
  logic level, press, rel, tog;

  key_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (4)
  ) dut (
    .Clock  (clk),
    .Resetn (rstn),
    .KeyRaw (key),
    .Level  (level),
    .Press  (press),
    .Release(rel),
    .Toggle (tog)
  );

  typedef struct {
    bit is_press;
    int edge_no;
    bit tog;
  } ev_t;

  ev_t sb[$];
  int  total = 0;
  int  bad = 0;
  int  edge_n = 0;
  bit  mon_en = 0;
  bit  exp_tog = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", nm, act, exp, edge_n);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Predict a pulse lat edges after the edge just passed.
  task automatic push_ev(input bit p, input int lat);
    ev_t e;
    e.is_press = p;
    e.edge_no  = edge_n + lat;
`ifdef KEYCOND_TOGGLE_EN
    if (p) exp_tog = ~exp_tog;
`endif
    e.tog = exp_tog;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (mon_en && (press || rel)) begin
      chk("press_release_exclusive", int'(press && rel), 0);
      if (sb.size() == 0) begin
        chk("unexpected_pulse_edge", edge_n, -1);
      end else begin
        ev_t e;
        e = sb.pop_front();
        chk("pulse_is_press", int'(press), int'(e.is_press));
        chk("pulse_edge", edge_n, e.edge_no);
        chk("pulse_level", int'(level), int'(e.is_press));
        chk("pulse_toggle", int'(tog), int'(e.tog));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rstn = 0;
    key  = 0;
    repeat (3) tick();
    chk("reset_level", int'(level), 0);
    chk("reset_press", int'(press), 0);
    chk("reset_release", int'(rel), 0);
    chk("reset_toggle", int'(tog), 0);
    mon_en = 1;

    // Key held through reset: accepted as a fresh press after full delay.
    rstn = 1;
    push_ev(1, 7);
    repeat (10) tick();
    chk("held_reset_level", int'(level), 1);
    key = 1;
    push_ev(0, 7);
    repeat (10) tick();
    chk("rel1_level", int'(level), 0);

    // Clean press and release.
    key = 0;
    push_ev(1, 7);
    repeat (12) tick();
    chk("clean_level", int'(level), 1);
    key = 1;
    push_ev(0, 7);
    repeat (10) tick();
    chk("clean_rel_level", int'(level), 0);

    // Bounce: low 2, high 1, then low; press 6 edges after final low capture.
    key = 0;
    push_ev(1, 10);
    tick(); tick();
    key = 1;
    tick();
    key = 0;
    repeat (12) tick();
    chk("bounce_level", int'(level), 1);
    key = 1;
    push_ev(0, 7);
    repeat (10) tick();
    chk("bounce_rel_level", int'(level), 0);

    // Three-cycle glitch must be rejected.
    key = 0;
    repeat (3) tick();
    key = 1;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("glitch_level", int'(level), 0);
    end

    // Reset while counting in PRESS_WAIT.
    key = 0;
    repeat (5) tick();
    chk("midcount_state", int'(dut.state_q), 1);
    chk("midcount_cnt", int'(dut.cnt_q), 2);
    rstn = 0;
    tick();
    chk("midreset_state", int'(dut.state_q), 0);
    chk("midreset_cnt", int'(dut.cnt_q), 0);
    chk("midreset_press", int'(press), 0);
    chk("midreset_level", int'(level), 0);
    rstn = 1;
    exp_tog = 0;
    push_ev(1, 7);
    repeat (10) tick();
    chk("post_mid_level", int'(level), 1);
    key = 1;
    push_ev(0, 7);
    repeat (10) tick();
    chk("final_level", int'(level), 0);
    chk("scoreboard_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
